// File: rtl/bet_collector.sv
// Bet table between the PS/2 key path and the regfile bet inputs.
// Filters break codes, validates chips, fills slots in order and locks during a spin.
//
// state   | meaning
// --------+----------------------------------------------
// EMPTY   | no bets stored
// COLLECT | 0 < bet_count < MAX_BETS, accepting bets
// FULL    | bet_count == MAX_BETS, bets refused
// SPIN    | table locked until spin_done
module bet_collector #(
    parameter int          MAX_BETS   = 12,
    parameter logic [5:0]  SPIN_OPC   = 6'b111110,
    parameter logic [5:0]  CLEAR_OPC  = 6'b111111,
    parameter logic [7:0]  BREAK_CODE = 8'hF0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  key_valid,
    input  logic [7:0]            key_code,
    input  logic [5:0]            bet_opcode,
    input  logic [2:0]            chip_color,
    input  logic                  spin_done,
    output logic [8*MAX_BETS-1:0] bets,
    output logic [4:0]            bet_count,
    output logic                  table_full,
    output logic                  spin_check,
    output logic                  bet_accept,
    output logic                  bet_reject
);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        COLLECT = 2'd1,
        FULL    = 2'd2,
        SPIN    = 2'd3
    } state_t;

    state_t                  state, state_n;
    logic                    skip, skip_n;
    logic [8*MAX_BETS-1:0]   bets_n;
    logic [4:0]              count_n;
    logic                    accept_n, reject_n;
    logic                    key_event;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= EMPTY;
            skip       <= 1'b0;
            bets       <= '0;
            bet_count  <= '0;
            table_full <= 1'b0;
            spin_check <= 1'b0;
            bet_accept <= 1'b0;
            bet_reject <= 1'b0;
        end else begin
            state      <= state_n;
            skip       <= skip_n;
            bets       <= bets_n;
            bet_count  <= count_n;
            table_full <= (count_n == 5'(MAX_BETS));
            spin_check <= (state_n == SPIN);
            bet_accept <= accept_n;
            bet_reject <= reject_n;
        end
    end

    // The byte following a break prefix is the release of a key and is dropped.
    always_comb begin
        skip_n    = skip;
        key_event = 1'b0;
        if (key_valid) begin
            if (skip)
                skip_n = 1'b0;
            else if (key_code == BREAK_CODE)
                skip_n = 1'b1;
            else
                key_event = 1'b1;
        end
    end

    always_comb begin
        state_n  = state;
        bets_n   = bets;
        count_n  = bet_count;
        accept_n = 1'b0;
        reject_n = 1'b0;
        case (state)
            SPIN: begin
                if (spin_done) begin
                    state_n = EMPTY;
                    bets_n  = '0;
                    count_n = '0;
                end
            end
            default: begin
                if (key_event) begin
                    if (bet_opcode == CLEAR_OPC) begin
                        state_n = EMPTY;
                        bets_n  = '0;
                        count_n = '0;
                    end else if (bet_opcode == SPIN_OPC) begin
                        if (bet_count != 5'd0)
                            state_n = SPIN;
                        else
                            reject_n = 1'b1;
                    end else if (chip_color == 3'b000 || state == FULL) begin
                        reject_n = 1'b1;
                    end else begin
                        // Slots fill in order; bet_count is the next free slot.
                        for (int i = 0; i < MAX_BETS; i++) begin
                            if (bet_count == 5'(i))
                                bets_n[8*i +: 8] = {chip_color[1:0], bet_opcode};
                        end
                        count_n  = bet_count + 5'd1;
                        accept_n = 1'b1;
                        state_n  = (count_n == 5'(MAX_BETS)) ? FULL : COLLECT;
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_bet_collector.sv
// Self-checking bench for bet_collector: directed scenarios followed by random
// traffic, compared cycle by cycle against a queue-based table model.
module tb_bet_collector;

    localparam int         MB    = 12;
    localparam logic [5:0] SPINO = 6'b111110;
    localparam logic [5:0] CLRO  = 6'b111111;
    localparam logic [7:0] BRK   = 8'hF0;

    logic            clock = 1'b0;
    logic            reset;
    logic            key_valid;
    logic [7:0]      key_code;
    logic [5:0]      bet_opcode;
    logic [2:0]      chip_color;
    logic            spin_done;
    logic [8*MB-1:0] bets;
    logic [4:0]      bet_count;
    logic            table_full;
    logic            spin_check;
    logic            bet_accept;
    logic            bet_reject;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: the table is simply an ordered list of stored bet bytes.
    logic [7:0] m_q[$];
    logic       m_skip;
    logic       m_spin;
    logic       m_acc;
    logic       m_rej;

    bet_collector #(
        .MAX_BETS(MB), .SPIN_OPC(SPINO), .CLEAR_OPC(CLRO), .BREAK_CODE(BRK)
    ) dut (
        .clock(clock), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .bet_opcode(bet_opcode), .chip_color(chip_color), .spin_done(spin_done),
        .bets(bets), .bet_count(bet_count), .table_full(table_full),
        .spin_check(spin_check), .bet_accept(bet_accept), .bet_reject(bet_reject)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic kv, input logic [7:0] code, input logic [5:0] opc,
                         input logic [2:0] col, input logic sd, input logic rs);
        logic ev;
        m_acc = 1'b0;
        m_rej = 1'b0;
        if (!rs) begin
            m_q.delete();
            m_skip = 1'b0;
            m_spin = 1'b0;
            return;
        end
        ev = 1'b0;
        if (kv) begin
            if (m_skip)          m_skip = 1'b0;
            else if (code == BRK) m_skip = 1'b1;
            else                 ev = 1'b1;
        end
        if (m_spin) begin
            if (sd) begin
                m_q.delete();
                m_spin = 1'b0;
            end
        end else if (ev) begin
            if (opc == CLRO)
                m_q.delete();
            else if (opc == SPINO) begin
                if (m_q.size() > 0) m_spin = 1'b1;
                else                m_rej  = 1'b1;
            end else if (col == 3'b000 || m_q.size() == MB)
                m_rej = 1'b1;
            else begin
                m_q.push_back({col[1:0], opc});
                m_acc = 1'b1;
            end
        end
    endtask

    task automatic step(input logic kv, input logic [7:0] code, input logic [5:0] opc,
                        input logic [2:0] col, input logic sd, input logic rs);
        logic [8*MB-1:0] exp_bets;
        key_valid  = kv;
        key_code   = code;
        bet_opcode = opc;
        chip_color = col;
        spin_done  = sd;
        reset      = rs;
        model(kv, code, opc, col, sd, rs);
        @(posedge clock);
        #1;
        exp_bets = '0;
        foreach (m_q[i]) exp_bets[8*i +: 8] = m_q[i];
        chk("bets",       128'(bets),       128'(exp_bets));
        chk("bet_count",  128'(bet_count),  128'(m_q.size()));
        chk("table_full", 128'(table_full), 128'(m_q.size() == MB));
        chk("spin_check", 128'(spin_check), 128'(m_spin));
        chk("bet_accept", 128'(bet_accept), 128'(m_acc));
        chk("bet_reject", 128'(bet_reject), 128'(m_rej));
        key_valid = 1'b0;
        spin_done = 1'b0;
        reset     = 1'b1;
    endtask

    task automatic bet(input logic [5:0] opc, input logic [2:0] col);
        step(1'b1, 8'h1C, opc, col, 1'b0, 1'b1);
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 6'd0, 3'b000, 1'b0, 1'b1);
    endtask

    initial begin
        logic [95:0] snap;
        logic [7:0]  rc;
        key_valid = 0; key_code = 0; bet_opcode = 0; chip_color = 0; spin_done = 0; reset = 0;
        m_skip = 0; m_spin = 0; m_acc = 0; m_rej = 0;
        #1;

        // Reset state
        step(1'b0, 8'h00, 6'd0, 3'b000, 1'b0, 1'b0);
        step(1'b0, 8'h00, 6'd0, 3'b000, 1'b0, 1'b0);
        chk("rst_bets", 128'(bets), 128'd0);

        // First bet
        step(1'b1, 8'h16, 6'd1, 3'b001, 1'b0, 1'b1);
        chk("first_slot", 128'(bets[7:0]), 128'h41);
        chk("first_acc",  128'(bet_accept), 128'd1);
        idle();
        chk("acc_one_cycle", 128'(bet_accept), 128'd0);

        // Break filter
        step(1'b1, 8'h2D, CLRO, 3'b000, 1'b0, 1'b1);
        step(1'b1, 8'h16, 6'd1, 3'b001, 1'b0, 1'b1);
        step(1'b1, BRK,   6'd0, 3'b001, 1'b0, 1'b1);
        step(1'b1, 8'h16, 6'd1, 3'b001, 1'b0, 1'b1);
        chk("break_no_acc", 128'(bet_accept), 128'd0);
        step(1'b1, 8'h1E, 6'd2, 3'b010, 1'b0, 1'b1);
        chk("break_count", 128'(bet_count), 128'd2);
        chk("slot1",       128'(bets[15:8]), 128'h82);

        // Fill to capacity, then overflow and no-chip rejects
        step(1'b1, 8'h2D, CLRO, 3'b000, 1'b0, 1'b1);
        for (int i = 0; i < MB; i++) bet(6'(i + 3), 3'(1 + (i % 3)));
        chk("full_flag", 128'(table_full), 128'd1);
        snap = bets;
        bet(6'd20, 3'b011);
        chk("overflow_rej",  128'(bet_reject), 128'd1);
        chk("overflow_keep", 128'(bets), 128'(snap));
        step(1'b1, 8'h2D, CLRO, 3'b000, 1'b0, 1'b1);
        bet(6'd4, 3'b001);
        bet(6'd5, 3'b000);
        chk("nochip_rej", 128'(bet_reject), 128'd1);
        chk("nochip_cnt", 128'(bet_count), 128'd1);

        // Spin with empty table, then a real spin
        step(1'b1, 8'h2D, CLRO, 3'b000, 1'b0, 1'b1);
        bet(SPINO, 3'b001);
        chk("spin_empty_rej", 128'(bet_reject), 128'd1);
        for (int i = 0; i < 3; i++) bet(6'(10 + i), 3'b001);
        bet(SPINO, 3'b000);
        chk("spin_on", 128'(spin_check), 128'd1);
        bet(6'd7, 3'b010);
        bet(CLRO, 3'b000);
        chk("spin_frozen", 128'(bet_count), 128'd3);
        step(1'b0, 8'h00, 6'd0, 3'b000, 1'b1, 1'b1);
        chk("spin_off", 128'(spin_check), 128'd0);

        // spin_done collides with a valid bet
        bet(6'd9, 3'b001);
        bet(6'd8, 3'b010);
        bet(SPINO, 3'b000);
        step(1'b1, 8'h1C, 6'd3, 3'b001, 1'b1, 1'b1);
        chk("collide_cnt", 128'(bet_count), 128'd0);
        chk("collide_acc", 128'(bet_accept), 128'd0);
        for (int i = 0; i < 5; i++) bet(6'(i + 1), 3'b011);
        bet(CLRO, 3'b000);
        chk("clear_cnt", 128'(bet_count), 128'd0);

        // Reset mid-spin
        for (int i = 0; i < 4; i++) bet(6'(i + 20), 3'b010);
        bet(SPINO, 3'b000);
        step(1'b0, 8'h00, 6'd0, 3'b000, 1'b0, 1'b0);
        chk("rst_spin", 128'(spin_check), 128'd0);
        bet(6'd1, 3'b001);
        chk("post_rst_acc", 128'(bet_accept), 128'd1);

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            rc = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 9) == 0 && !m_skip) rc = BRK;
            else if (rc == BRK) rc = 8'h1C;
            step(1'($urandom_range(0, 3) != 0), rc,
                 ($urandom_range(0, 9) == 0) ? SPINO :
                 ($urandom_range(0, 19) == 0) ? CLRO : 6'($urandom_range(0, 61)),
                 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 99) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bet_collector.md
Name: bet_collector

Overview:
- Sits between the PS/2 keyboard path (scan byte plus decoded bet opcode) and the regfile bet inputs.
- Filters PS/2 break sequences, validates each bet against the Arduino chip-colour sensor, and stores up to MAX_BETS bets in fixed slots.
- Raises spin_check to lock the table during a spin and clears the table when the processor signals spin completion.
- Replaces the ad-hoc bet latch and the even-count make/break hack.

Parameters:
- MAX_BETS, 12, number of bet slots (1..31).
- SPIN_OPC, 6'b111110, opcode that requests a spin.
- CLEAR_OPC, 6'b111111, opcode that clears all bets.
- BREAK_CODE, 8'hF0, PS/2 break prefix byte.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous reset, active-low (asserted when 0, sampled on posedge clock).
- key_valid  in  1  one-cycle pulse: new PS/2 byte available.
- key_code  in  8  raw PS/2 byte, valid with key_valid.
- bet_opcode  in  6  decoded opcode for key_code (combinational, same cycle).
- chip_color  in  3  Arduino colour sensor; 3'b000 means no chip.
- spin_done  in  1  pulse from the processor side: spin and payout finished.
- bets  out  8*MAX_BETS  flat slot array; slot i is bits [8i+7:8i], formatted {color[1:0], opcode[5:0]}.
- bet_count  out  5  number of filled slots.
- table_full  out  1  bet_count == MAX_BETS.
- spin_check  out  1  high while in SPIN.
- bet_accept  out  1  one-cycle pulse: a bet was stored.
- bet_reject  out  1  one-cycle pulse: a candidate bet was refused.

Behaviour:
- Reset (reset==0): all slots 0, bet_count 0, skip flag 0, state EMPTY; all outputs 0.
- States:
  - EMPTY: bet_count==0.
  - COLLECT: 0<bet_count<MAX_BETS.
  - FULL: bet_count==MAX_BETS.
  - SPIN.
  - State is registered; all outputs are registered, so there is 1-cycle latency from key_valid to the visible effect.
- Break filter: key_valid with key_code==BREAK_CODE sets skip (any state), no other effect. The next key_valid clears skip and is discarded entirely, including in SPIN.
- Event classification: any key_valid that is not BREAK_CODE and not skipped is an event, classified by bet_opcode.
- Event in EMPTY/COLLECT/FULL:
  - CLEAR_OPC: all slots 0, count 0, go EMPTY; no accept/reject pulse.
  - SPIN_OPC with count>=1: go SPIN, spin_check=1 next cycle. SPIN_OPC with count==0: bet_reject, stay EMPTY.
  - Other opcode with chip_color==0: bet_reject, no write.
  - Other opcode in FULL: bet_reject, no write.
  - Otherwise: write {chip_color[1:0], bet_opcode} to slot bet_count, bet_count+1, bet_accept. Go COLLECT, or FULL if the new count == MAX_BETS.
- SPIN:
  - Slots and count are frozen; events are ignored with no pulses.
  - spin_done: all slots 0, count 0, go EMPTY next cycle; spin_check falls the same edge.
  - spin_done outside SPIN is ignored.
  - spin_done and key_valid in the same cycle in SPIN: spin_done wins and the key is dropped (the skip flag is still updated).
- No wrap-around: slots are never overwritten except by clear or spin_done. bet_count saturates at MAX_BETS.
- bet_accept and bet_reject are mutually exclusive and last exactly one cycle.
- Reset asserted mid-spin or mid-collection: immediate full clear on that edge; spin_check drops.

Test Plan:
- Reset release, then key 8'h16 / opc 6'd1 / color 3'b001 -> next cycle bets[7:0]=8'h41, bet_count=1, bet_accept pulse, state COLLECT.
- Key 8'h16 (color 1), then F0, then 8'h16 again, then key 8'h1E / opc 6'd2 / color 3'b010 -> exactly 2 bets stored; slot1=8'h82; second 8'h16 discarded with no pulse.
- 12 valid bets, then a 13th -> table_full=1, bet_count=12, 13th gives bet_reject and slot contents unchanged. Separately, a bet with color 3'b000 -> bet_reject, count unchanged.
- SPIN_OPC with count 0 -> bet_reject, spin_check stays 0. With 3 bets -> spin_check=1; further keys ignored; spin_done -> next cycle spin_check=0, bets all 0, bet_count=0.
- spin_done and key_valid (valid bet) in the same cycle during SPIN -> table cleared, no bet stored, no pulse. CLEAR_OPC with 5 bets -> count 0, no pulses.
- reset=0 for one cycle while in SPIN with 4 bets -> all outputs 0 next cycle; bets accepted normally afterward.
